pc_sequencer: RTL and testbench

Program-counter sequencer for the multicycle MIPS datapath. It owns the PC register, fetches each instruction from memory over a req/ack handshake, and latches the instruction. It writes back the incremented PC produced by the datapath's PC + 4 incrementer, which is driven from this block's `Pc` output. On a commit pulse from the main controller it applies the branch, jump or jump-register redirect.

---
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multicycle MIPS datapath: owns the PC,
// fetches over a req/ack handshake, and applies branch/jump/jr redirects on commit.
module pc_sequencer #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = 32'h0040_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] Pc_Plus4,
  input  logic [WORD_LENGTH-1:0] Branch_Target,
  input  logic [WORD_LENGTH-1:0] Jr_Target,
  input  logic [25:0]            Jump_Field,
  input  logic                   Zero,
  input  logic                   Branch_Ne,
  input  logic [1:0]             Next_Sel,
  input  logic                   Commit,
  input  logic                   Fetch_Ack,
  input  logic [WORD_LENGTH-1:0] Mem_Data,
  output logic [WORD_LENGTH-1:0] Pc,
  output logic [WORD_LENGTH-1:0] Old_Pc,
  output logic [WORD_LENGTH-1:0] Instr,
  output logic                   Instr_Valid,
  output logic                   Fetch_Req,
  output logic                   Addr_Error
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [WORD_LENGTH-1:0] pc_q;
  logic [WORD_LENGTH-1:0] old_pc_q;
  logic [WORD_LENGTH-1:0] instr_q;
  logic                   instr_valid_q;
  logic                   addr_error_q;

  logic [WORD_LENGTH-1:0] jump_target;
  logic [WORD_LENGTH-1:0] redirect_target;
  logic                   redirect_taken;
  logic                   redirect_misaligned;

  // pc_q already holds Old_Pc + 4 here, so its top nibble is the MIPS j/jal region.
  assign jump_target = {pc_q[WORD_LENGTH-1:28], Jump_Field, 2'b00};

  always_comb begin
    redirect_taken  = 1'b0;
    redirect_target = pc_q;
    case (Next_Sel)
      2'b01: begin
        redirect_taken  = Zero ^ Branch_Ne;
        redirect_target = Branch_Target;
      end
      2'b10: begin
        redirect_taken  = 1'b1;
        redirect_target = jump_target;
      end
      2'b11: begin
        redirect_taken  = 1'b1;
        redirect_target = Jr_Target;
      end
      default: begin
        redirect_taken  = 1'b0;
        redirect_target = pc_q;
      end
    endcase
  end

  assign redirect_misaligned = redirect_taken && (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      old_pc_q      <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      addr_error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (Fetch_Ack) begin
            instr_q       <= Mem_Data;
            old_pc_q      <= pc_q;
            pc_q          <= Pc_Plus4;
            instr_valid_q <= 1'b1;
            state_q       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (Commit) begin
            instr_valid_q <= 1'b0;
            if (redirect_misaligned) begin
              // A bad target freezes the machine; only reset recovers.
              addr_error_q <= 1'b1;
              state_q      <= ST_HALT;
            end else begin
              if (redirect_taken) begin
                pc_q <= redirect_target;
              end
              state_q <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign Pc          = pc_q;
  assign Old_Pc      = old_pc_q;
  assign Instr       = instr_q;
  assign Instr_Valid = instr_valid_q;
  assign Fetch_Req   = (state_q == ST_FETCH);
  assign Addr_Error  = addr_error_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table of fetch/commit pairs plus
// hand-written reset, halt, back-to-back and reset-during-commit sequences.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Pc_Plus4;
  logic [31:0] Branch_Target;
  logic [31:0] Jr_Target;
  logic [25:0] Jump_Field;
  logic        Zero;
  logic        Branch_Ne;
  logic [1:0]  Next_Sel;
  logic        Commit;
  logic        Fetch_Ack;
  logic [31:0] Mem_Data;
  logic [31:0] Pc;
  logic [31:0] Old_Pc;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic        Fetch_Req;
  logic        Addr_Error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External PC + 4 incrementer, wrapping modulo 2^32.
  assign Pc_Plus4 = Pc + 32'd4;

  pc_sequencer #(.WORD_LENGTH(32), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .Pc_Plus4     (Pc_Plus4),
    .Branch_Target(Branch_Target),
    .Jr_Target    (Jr_Target),
    .Jump_Field   (Jump_Field),
    .Zero         (Zero),
    .Branch_Ne    (Branch_Ne),
    .Next_Sel     (Next_Sel),
    .Commit       (Commit),
    .Fetch_Ack    (Fetch_Ack),
    .Mem_Data     (Mem_Data),
    .Pc           (Pc),
    .Old_Pc       (Old_Pc),
    .Instr        (Instr),
    .Instr_Valid  (Instr_Valid),
    .Fetch_Req    (Fetch_Req),
    .Addr_Error   (Addr_Error)
  );

  typedef struct {
    logic [31:0] mem;
    int          ack_wait;
    int          hold_wait;
    logic [1:0]  sel;
    logic        zero;
    logic        bne;
    logic [31:0] bt;
    logic [31:0] jr;
    logic [25:0] jf;
    logic [31:0] exp_old;
    logic [31:0] exp_pc_ack;
    logic [31:0] exp_pc_final;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Commit        = 1'b0;
    Fetch_Ack     = 1'b0;
    Next_Sel      = 2'b00;
    Zero          = 1'b0;
    Branch_Ne     = 1'b0;
    Branch_Target = 32'h0;
    Jr_Target     = 32'h0;
    Jump_Field    = 26'h0;
    Mem_Data      = 32'h0;
  endtask

  // Wait ack_wait cycles with Fetch_Req asserted and Pc stable, then ack.
  task automatic do_fetch(input logic [31:0] data, input int ack_wait,
                          input logic [31:0] exp_old, input logic [31:0] exp_pc);
    logic [31:0] pc_before;
    pc_before = Pc;
    for (int w = 0; w < ack_wait; w++) begin
      tick();
      chk("fetch_req_wait", {31'b0, Fetch_Req}, 32'd1);
      chk("pc_stable_fetch", Pc, pc_before);
    end
    Fetch_Ack = 1'b1;
    Mem_Data  = data;
    tick();
    Fetch_Ack = 1'b0;
    Mem_Data  = 32'hDEAD_BEEF;
    chk("instr", Instr, data);
    chk("old_pc", Old_Pc, exp_old);
    chk("pc_after_ack", Pc, exp_pc);
    chk("instr_valid_ack", {31'b0, Instr_Valid}, 32'd1);
    chk("fetch_req_hold", {31'b0, Fetch_Req}, 32'd0);
  endtask

  initial begin
    // mem, ack_wait, hold_wait, sel, zero, bne, bt, jr, jf, old, pc_ack, pc_final
    vecs[0] = '{32'h2008_0005, 2, 0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0,
                32'h0040_0000, 32'h0040_0004, 32'h0040_0004};
    vecs[1] = '{32'h1109_0006, 0, 1, 2'b01, 1'b1, 1'b0, 32'h0040_0020, 32'h0, 26'h0,
                32'h0040_0004, 32'h0040_0008, 32'h0040_0020};
    vecs[2] = '{32'h1509_0006, 1, 0, 2'b01, 1'b1, 1'b1, 32'h0040_0040, 32'h0, 26'h0,
                32'h0040_0020, 32'h0040_0024, 32'h0040_0024};
    vecs[3] = '{32'h1509_FFF8, 0, 2, 2'b01, 1'b0, 1'b1, 32'h0040_0008, 32'h0, 26'h0,
                32'h0040_0024, 32'h0040_0028, 32'h0040_0008};
    vecs[4] = '{32'h0810_0004, 3, 0, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 26'h010_0004,
                32'h0040_0008, 32'h0040_000C, 32'h0040_0010};
    vecs[5] = '{32'h0100_0008, 0, 0, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0040_0100, 26'h0,
                32'h0040_0010, 32'h0040_0014, 32'h0040_0100};
    vecs[6] = '{32'h1000_0003, 1, 1, 2'b01, 1'b0, 1'b0, 32'h0040_0003, 32'h0, 26'h0,
                32'h0040_0100, 32'h0040_0104, 32'h0040_0104};
    vecs[7] = '{32'h0300_0008, 0, 0, 2'b11, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 26'h0,
                32'h0040_0104, 32'h0040_0108, 32'hFFFF_FFFC};
    vecs[8] = '{32'h0000_0000, 2, 0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0,
                32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};

    // Reset with a stray ack asserted: the ack must be ignored.
    idle_inputs();
    reset     = 1'b1;
    Fetch_Ack = 1'b1;
    Mem_Data  = 32'h1234_5678;
    tick();
    tick();
    chk("fetch_req_in_reset", {31'b0, Fetch_Req}, 32'd1);
    chk("pc_in_reset", Pc, RST_PC);
    Fetch_Ack = 1'b0;
    reset     = 1'b0;
    tick();
    chk("rst_pc", Pc, RST_PC);
    chk("rst_old_pc", Old_Pc, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", {31'b0, Instr_Valid}, 32'd0);
    chk("rst_addr_err", {31'b0, Addr_Error}, 32'd0);
    chk("rst_fetch_req", {31'b0, Fetch_Req}, 32'd1);

    foreach (vecs[i]) begin
      $display("vec %0d: sel=%0b instr=0x%08h expect pc 0x%08h", i, vecs[i].sel,
               vecs[i].mem, vecs[i].exp_pc_final);
      do_fetch(vecs[i].mem, vecs[i].ack_wait, vecs[i].exp_old, vecs[i].exp_pc_ack);
      for (int w = 0; w < vecs[i].hold_wait; w++) begin
        tick();
        chk("pc_stable_hold", Pc, vecs[i].exp_pc_ack);
        chk("valid_hold", {31'b0, Instr_Valid}, 32'd1);
      end
      Commit        = 1'b1;
      Next_Sel      = vecs[i].sel;
      Zero          = vecs[i].zero;
      Branch_Ne     = vecs[i].bne;
      Branch_Target = vecs[i].bt;
      Jr_Target     = vecs[i].jr;
      Jump_Field    = vecs[i].jf;
      tick();
      idle_inputs();
      chk("pc_after_commit", Pc, vecs[i].exp_pc_final);
      chk("fetch_req_after_commit", {31'b0, Fetch_Req}, 32'd1);
      chk("valid_after_commit", {31'b0, Instr_Valid}, 32'd0);
      chk("addr_err_clean", {31'b0, Addr_Error}, 32'd0);
    end

    // Misaligned jr: halt with Pc frozen, immune to stray ack/commit.
    $display("misaligned jr to 0x00000006");
    do_fetch(32'h0060_0008, 0, 32'h0000_0000, 32'h0000_0004);
    Commit    = 1'b1;
    Next_Sel  = 2'b11;
    Jr_Target = 32'h0000_0006;
    tick();
    idle_inputs();
    chk("halt_addr_err", {31'b0, Addr_Error}, 32'd1);
    chk("halt_pc", Pc, 32'h0000_0004);
    chk("halt_valid", {31'b0, Instr_Valid}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      Fetch_Ack = c[0];
      Commit    = ~c[0];
      Next_Sel  = 2'b11;
      Jr_Target = 32'h0000_0100;
      Mem_Data  = 32'hFFFF_0000;
      tick();
      chk("halt_fetch_req", {31'b0, Fetch_Req}, 32'd0);
      chk("halt_pc_frozen", Pc, 32'h0000_0004);
    end
    chk("halt_instr_frozen", Instr, 32'h0060_0008);
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_reset_pc", Pc, RST_PC);
    chk("halt_reset_addr_err", {31'b0, Addr_Error}, 32'd0);
    chk("halt_reset_fetch_req", {31'b0, Fetch_Req}, 32'd1);

    // Back-to-back: stray commit with every ack, stray ack with every commit.
    for (int k = 0; k < 8; k++) begin
      Fetch_Ack = 1'b1;
      Mem_Data  = 32'hA000_0000 + k;
      Commit    = 1'b1;
      Next_Sel  = 2'b11;
      Jr_Target = 32'h0000_0800;
      tick();
      $display("b2b %0d: pc=0x%08h instr=0x%08h", k, Pc, Instr);
      chk("b2b_req_low", {31'b0, Fetch_Req}, 32'd0);
      chk("b2b_instr", Instr, 32'hA000_0000 + k);
      chk("b2b_pc_ack", Pc, RST_PC + 32'd4 * (k + 1));
      Fetch_Ack = 1'b1;
      Mem_Data  = 32'h5555_5555;
      Commit    = 1'b1;
      Next_Sel  = 2'b00;
      tick();
      chk("b2b_req_high", {31'b0, Fetch_Req}, 32'd1);
      chk("b2b_instr_kept", Instr, 32'hA000_0000 + k);
      chk("b2b_pc_commit", Pc, RST_PC + 32'd4 * (k + 1));
    end
    idle_inputs();

    // Reset and commit on the same edge in HOLD: reset wins.
    do_fetch(32'h0300_0008, 1, 32'h0040_0020, 32'h0040_0024);
    reset     = 1'b1;
    Commit    = 1'b1;
    Next_Sel  = 2'b11;
    Jr_Target = 32'h0050_0000;
    tick();
    idle_inputs();
    reset = 1'b0;
    chk("rst_commit_pc", Pc, RST_PC);
    chk("rst_commit_old_pc", Old_Pc, 32'h0);
    chk("rst_commit_instr", Instr, 32'h0);
    chk("rst_commit_valid", {31'b0, Instr_Valid}, 32'd0);
    chk("rst_commit_req", {31'b0, Fetch_Req}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
